// File: rtl/sargantana_icache_ifill_responder.sv
// Upper-level iFill responder: one outstanding line fill assembled from memory beats,
// plus a 1-entry invalidation forwarder. Optional fill-latency counter: SARGANTANA_IFILL_LAT_CNT_EN.
module sargantana_icache_ifill_responder #(
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BEAT_W  = 64,
  parameter int unsigned WAY_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ifill_req_valid_i,
  input  logic [PADDR_W-1:0] ifill_req_paddr_i,
  input  logic [WAY_W-1:0]   ifill_req_way_i,
  output logic               ifill_req_ready_o,
  output logic               ifill_resp_valid_o,
  output logic               ifill_resp_ack_o,
  output logic [LINE_W-1:0]  ifill_resp_data_o,
  output logic [1:0]         ifill_resp_beat_o,
  output logic [WAY_W-1:0]   ifill_resp_way_o,
  output logic               ifill_resp_inv_valid_o,
  output logic [PADDR_W-1:0] ifill_resp_inv_paddr_o,
  output logic               mem_req_valid_o,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_req_ready_i,
  input  logic               mem_resp_valid_i,
  input  logic [BEAT_W-1:0]  mem_resp_data_i,
  input  logic               inv_valid_i,
  input  logic [PADDR_W-1:0] inv_paddr_i,
  output logic               inv_ready_o
`ifdef SARGANTANA_IFILL_LAT_CNT_EN
  ,
  output logic [15:0]        fill_lat_o
`endif
);

  localparam int unsigned N_BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W   = $clog2(N_BEATS);
  localparam int unsigned OFF_W   = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(N_BEATS - 1);
  localparam logic [1:0]         LAST_BEAT = 2'(N_BEATS - 1);
  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_BEATS, RESP} state_t;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [WAY_W-1:0]   way;
  } fill_req_t;

  state_t             state_q, state_d;
  fill_req_t          req_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINE_W-1:0]  line_q;
  logic               inv_vld_q;
  logic [PADDR_W-1:0] inv_paddr_q;

  logic accept, mem_hs, beat_en, inv_emit, inv_cap;

  // Pending invalidations win over new requests, but only while no fill is in flight.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mem_hs   = 1'b0;
    beat_en  = 1'b0;
    inv_emit = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_vld_q) begin
          inv_emit = 1'b1;
        end else if (ifill_req_valid_i) begin
          accept  = 1'b1;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready_i) begin
          mem_hs  = 1'b1;
          state_d = MEM_BEATS;
        end
      end
      MEM_BEATS: begin
        if (mem_resp_valid_i) begin
          beat_en = 1'b1;
          if (cnt_q == LAST_CNT) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign inv_cap = inv_valid_i && !inv_vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= '0;
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      if (accept) begin
        req_q.paddr <= ifill_req_paddr_i & LINE_MASK;
        req_q.way   <= ifill_req_way_i;
      end
      if (mem_hs) cnt_q <= '0;
      else if (beat_en) cnt_q <= cnt_q + 1'b1;
      for (int b = 0; b < int'(N_BEATS); b++) begin
        if (beat_en && cnt_q == CNT_W'(b)) line_q[b*BEAT_W +: BEAT_W] <= mem_resp_data_i;
      end
    end
  end

  // Capture requires an empty buffer, so capture and emission never coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inv_vld_q   <= 1'b0;
      inv_paddr_q <= '0;
    end else if (inv_cap) begin
      inv_vld_q   <= 1'b1;
      inv_paddr_q <= inv_paddr_i;
    end else if (inv_emit) begin
      inv_vld_q   <= 1'b0;
      inv_paddr_q <= '0;
    end
  end

  assign ifill_req_ready_o      = accept;
  assign ifill_resp_ack_o       = (state_q == RESP);
  assign ifill_resp_valid_o     = ifill_resp_ack_o || inv_emit;
  assign ifill_resp_data_o      = line_q;
  assign ifill_resp_beat_o      = ifill_resp_ack_o ? LAST_BEAT : 2'b0;
  assign ifill_resp_way_o       = ifill_resp_ack_o ? req_q.way : '0;
  assign ifill_resp_inv_valid_o = inv_emit;
  assign ifill_resp_inv_paddr_o = inv_emit ? inv_paddr_q : '0;
  assign mem_req_valid_o        = (state_q == MEM_REQ);
  assign mem_req_addr_o         = mem_req_valid_o ? req_q.paddr : '0;
  assign inv_ready_o            = !inv_vld_q;

`ifdef SARGANTANA_IFILL_LAT_CNT_EN
  logic [15:0] lat_cnt_q, lat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      if (accept) lat_cnt_q <= '0;
      else if ((state_q == MEM_REQ || state_q == MEM_BEATS) && lat_cnt_q != 16'hFFFF)
        lat_cnt_q <= lat_cnt_q + 16'd1;
      if (state_q == RESP) lat_q <= lat_cnt_q;
    end
  end

  // Live count during the response cycle, captured copy afterwards.
  assign fill_lat_o = (state_q == RESP) ? lat_cnt_q : lat_q;
`endif

endmodule

// File: tb/tb_sargantana_icache_ifill_responder.sv
// Directed bench for the iFill responder: fills, back-pressure, invalidations, mid-fill reset.
module tb_sargantana_icache_ifill_responder;
  localparam int PADDR_W = 40;
  localparam int LINE_W  = 256;
  localparam int BEAT_W  = 64;
  localparam int WAY_W   = 2;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               ifill_req_valid_i;
  logic [PADDR_W-1:0] ifill_req_paddr_i;
  logic [WAY_W-1:0]   ifill_req_way_i;
  logic               ifill_req_ready_o;
  logic               ifill_resp_valid_o;
  logic               ifill_resp_ack_o;
  logic [LINE_W-1:0]  ifill_resp_data_o;
  logic [1:0]         ifill_resp_beat_o;
  logic [WAY_W-1:0]   ifill_resp_way_o;
  logic               ifill_resp_inv_valid_o;
  logic [PADDR_W-1:0] ifill_resp_inv_paddr_o;
  logic               mem_req_valid_o;
  logic [PADDR_W-1:0] mem_req_addr_o;
  logic               mem_req_ready_i;
  logic               mem_resp_valid_i;
  logic [BEAT_W-1:0]  mem_resp_data_i;
  logic               inv_valid_i;
  logic [PADDR_W-1:0] inv_paddr_i;
  logic               inv_ready_o;
`ifdef SARGANTANA_IFILL_LAT_CNT_EN
  logic [15:0]        fill_lat_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sargantana_icache_ifill_responder #(
    .PADDR_W(PADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .WAY_W(WAY_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifill_req_valid_i(ifill_req_valid_i), .ifill_req_paddr_i(ifill_req_paddr_i),
    .ifill_req_way_i(ifill_req_way_i), .ifill_req_ready_o(ifill_req_ready_o),
    .ifill_resp_valid_o(ifill_resp_valid_o), .ifill_resp_ack_o(ifill_resp_ack_o),
    .ifill_resp_data_o(ifill_resp_data_o), .ifill_resp_beat_o(ifill_resp_beat_o),
    .ifill_resp_way_o(ifill_resp_way_o), .ifill_resp_inv_valid_o(ifill_resp_inv_valid_o),
    .ifill_resp_inv_paddr_o(ifill_resp_inv_paddr_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .inv_valid_i(inv_valid_i),
    .inv_paddr_i(inv_paddr_i), .inv_ready_o(inv_ready_o)
`ifdef SARGANTANA_IFILL_LAT_CNT_EN
    , .fill_lat_o(fill_lat_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [BEAT_W-1:0] d);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = d;
    tick();
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
  endtask

  task automatic chk_resp(input string tag, input logic [LINE_W-1:0] line, input logic [WAY_W-1:0] way);
    #1;
    chk({tag, ".valid"}, LINE_W'(ifill_resp_valid_o), LINE_W'(1));
    chk({tag, ".ack"},   LINE_W'(ifill_resp_ack_o), LINE_W'(1));
    chk({tag, ".inv"},   LINE_W'(ifill_resp_inv_valid_o), LINE_W'(0));
    chk({tag, ".data"},  ifill_resp_data_o, line);
    chk({tag, ".way"},   LINE_W'(ifill_resp_way_o), LINE_W'(way));
    chk({tag, ".beat"},  LINE_W'(ifill_resp_beat_o), LINE_W'(3));
  endtask

  // Accept request, immediate memory handshake, four back-to-back beats, check RESP.
  task automatic fill(input string tag, input logic [PADDR_W-1:0] pa, input logic [WAY_W-1:0] way,
                      input logic [PADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] line);
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = pa;
    ifill_req_way_i   = way;
    mem_req_ready_i   = 1'b1;
    #1;
    chk({tag, ".req_ready"}, LINE_W'(ifill_req_ready_o), LINE_W'(1));
    tick();
    ifill_req_valid_i = 1'b0;
    #1;
    chk({tag, ".mem_valid"}, LINE_W'(mem_req_valid_o), LINE_W'(1));
    chk({tag, ".mem_addr"},  LINE_W'(mem_req_addr_o), LINE_W'(exp_addr));
    tick();
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) beat(line[b*BEAT_W +: BEAT_W]);
    chk_resp(tag, line, way);
    tick();
    #1;
    chk({tag, ".after"}, LINE_W'(ifill_resp_valid_o), LINE_W'(0));
  endtask

  logic [LINE_W-1:0]  exp_line;
  logic [PADDR_W-1:0] addr0;

  initial begin
    rst_i = 1'b1;
    ifill_req_valid_i = 1'b0; ifill_req_paddr_i = '0; ifill_req_way_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    inv_valid_i = 1'b0; inv_paddr_i = '0;
    tick(); tick();
    chk("rst.resp_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(0));
    chk("rst.req_ready",  LINE_W'(ifill_req_ready_o), LINE_W'(0));
    chk("rst.mem_valid",  LINE_W'(mem_req_valid_o), LINE_W'(0));
    chk("rst.inv_ready",  LINE_W'(inv_ready_o), LINE_W'(1));
    chk("rst.data",       ifill_resp_data_o, LINE_W'(0));
    rst_i = 1'b0;
    tick();

    // Basic fill
    exp_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    fill("basic", 40'h00_8000_1234, 2'd2, 40'h00_8000_1220, exp_line);

    // Back-pressure and gapped beats; request held high to show ready stays low
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h12_3456_78FF;
    ifill_req_way_i   = 2'd1;
    tick();
    addr0 = 40'h12_3456_78E0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.mem_valid", LINE_W'(mem_req_valid_o), LINE_W'(1));
      chk("bp.mem_addr",  LINE_W'(mem_req_addr_o), LINE_W'(addr0));
      chk("bp.req_ready", LINE_W'(ifill_req_ready_o), LINE_W'(0));
      tick();
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    exp_line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("bp.gap_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(0));
      chk("bp.gap_ready", LINE_W'(ifill_req_ready_o), LINE_W'(0));
      tick();
      if (b == 3) ifill_req_valid_i = 1'b0;
      beat(exp_line[b*BEAT_W +: BEAT_W]);
    end
    chk_resp("bp", exp_line, 2'd1);
    tick();

    // Invalidation arriving during the beat phase waits for the fill response
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h00_8000_0000;
    ifill_req_way_i   = 2'd3;
    mem_req_ready_i   = 1'b1;
    tick();
    ifill_req_valid_i = 1'b0;
    tick();
    mem_req_ready_i = 1'b0;
    exp_line = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
    beat(exp_line[63:0]);
    inv_valid_i = 1'b1;
    inv_paddr_i = 40'h00_9000_0040;
    #1;
    chk("invf.ready_before", LINE_W'(inv_ready_o), LINE_W'(1));
    beat(exp_line[127:64]);
    inv_valid_i = 1'b0;
    #1;
    chk("invf.ready_after", LINE_W'(inv_ready_o), LINE_W'(0));
    chk("invf.no_early",    LINE_W'(ifill_resp_valid_o), LINE_W'(0));
    beat(exp_line[191:128]);
    beat(exp_line[255:192]);
    chk_resp("invf", exp_line, 2'd3);
    tick();
    chk("invf.inv_resp_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(1));
    chk("invf.inv_ack",        LINE_W'(ifill_resp_ack_o), LINE_W'(0));
    chk("invf.inv_valid",      LINE_W'(ifill_resp_inv_valid_o), LINE_W'(1));
    chk("invf.inv_paddr",      LINE_W'(ifill_resp_inv_paddr_o), LINE_W'(40'h00_9000_0040));
    tick();
    chk("invf.ready_free",     LINE_W'(inv_ready_o), LINE_W'(1));
    chk("invf.resp_idle",      LINE_W'(ifill_resp_valid_o), LINE_W'(0));

    // Pending invalidation and request in IDLE: invalidation first, request next cycle
    inv_valid_i = 1'b1;
    inv_paddr_i = 40'h01_0000_0080;
    tick();
    inv_valid_i = 1'b0;
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h00_0000_0045;
    ifill_req_way_i   = 2'd0;
    #1;
    chk("invi.resp_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(1));
    chk("invi.inv_valid",  LINE_W'(ifill_resp_inv_valid_o), LINE_W'(1));
    chk("invi.inv_paddr",  LINE_W'(ifill_resp_inv_paddr_o), LINE_W'(40'h01_0000_0080));
    chk("invi.req_ready",  LINE_W'(ifill_req_ready_o), LINE_W'(0));
    tick();
    exp_line = {{16{4'hF}}, {16{4'hE}}, {16{4'h9}}, {16{4'h0}}};
    fill("invi", 40'h00_0000_0045, 2'd0, 40'h00_0000_0040, exp_line);

    // Reset after two beats aborts the fill; stray beats are ignored
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h00_0000_2000;
    ifill_req_way_i   = 2'd1;
    mem_req_ready_i   = 1'b1;
    tick();
    ifill_req_valid_i = 1'b0;
    tick();
    mem_req_ready_i = 1'b0;
    beat({16{4'hA}});
    beat({16{4'hB}});
    rst_i = 1'b1;
    #1;
    chk("rstm.resp_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(0));
    chk("rstm.mem_valid",  LINE_W'(mem_req_valid_o), LINE_W'(0));
    chk("rstm.inv_ready",  LINE_W'(inv_ready_o), LINE_W'(1));
    chk("rstm.data",       ifill_resp_data_o, LINE_W'(0));
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat({16{4'hC}});
      #1;
      chk("rstm.stray_valid", LINE_W'(ifill_resp_valid_o), LINE_W'(0));
      chk("rstm.stray_data",  ifill_resp_data_o, LINE_W'(0));
    end
    exp_line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    fill("rstm.next", 40'h00_0000_3010, 2'd0, 40'h00_0000_3000, exp_line);

`ifdef SARGANTANA_IFILL_LAT_CNT_EN
    // Two not-ready cycles + one handshake cycle + four beats = 7
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h00_0000_4000;
    ifill_req_way_i   = 2'd2;
    mem_req_ready_i   = 1'b0;
    tick();
    ifill_req_valid_i = 1'b0;
    tick(); tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) beat(exp_line[b*BEAT_W +: BEAT_W]);
    chk_resp("lat", exp_line, 2'd2);
    chk("lat.value", LINE_W'(fill_lat_o), LINE_W'(7));
    tick();
    chk("lat.hold", LINE_W'(fill_lat_o), LINE_W'(7));
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
